// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: pattern codes,
// FSM state type and the fixed 8-step pattern ROM.
`timescale 1ns/1ps
package led_pkg;

  // 3-bit pattern codes selectable by each requester
  localparam logic [2:0] PAT_OFF    = 3'd0;
  localparam logic [2:0] PAT_ON     = 3'd1;
  localparam logic [2:0] PAT_SLOW   = 3'd2;
  localparam logic [2:0] PAT_FAST   = 3'd3;
  localparam logic [2:0] PAT_HEART  = 3'd4;
  localparam logic [2:0] PAT_DOUBLE = 3'd5;
  localparam logic [2:0] PAT_TRIPLE = 3'd6;
  localparam logic [2:0] PAT_RSVD   = 3'd7;

  // Index of the final step in a frame
  localparam logic [2:0] LAST_STEP = 3'd7;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Pattern ROM: bit 0 of the frame is shown first, bit 7 last
  function automatic logic [7:0] pat_frame(input logic [2:0] code);
    logic [7:0] frame;
    case (code)
      PAT_OFF:    frame = 8'b0000_0000;
      PAT_ON:     frame = 8'b1111_1111;
      PAT_SLOW:   frame = 8'b0000_1111;
      PAT_FAST:   frame = 8'b0101_0101;
      PAT_HEART:  frame = 8'b0000_0101;
      PAT_DOUBLE: frame = 8'b0000_0011;
      PAT_TRIPLE: frame = 8'b0111_0111;
      PAT_RSVD:   frame = 8'b0000_0000;
      default:    frame = 8'b0000_0000;
    endcase
    return frame;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle on
// the last count. clr holds the count at zero so a new owner always starts
// with a full-length first step.
`timescale 1ns/1ps
module led_tick_gen #(
  parameter int TICK_DIV = 2_700_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Tick is decoded from the registered count, so it is glitch-free
  assign tick = (cnt == CNT_MAX);

  // Free-running modulo-TICK_DIV counter, zeroed by reset or clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Arbitrated LED pattern sequencer. A fixed-priority arbiter (index 0 wins)
// hands the single status LED to one requester, whose pattern code is
// latched at grant and stepped once per prescaler tick. On release the
// current frame is finished (DRAIN) before the LED returns to IDLE.
//
// Optional feature macro: LED_PREEMPT_EN. When defined, a higher-priority
// requester takes over at the tick that ends step 7 of a RUN frame.
//
// Handshake: req is a level; gnt is a registered one-hot level that stays
// high while the owner holds req high and drops the edge after req is
// sampled low. Non-owner requests are only considered from IDLE (or at the
// frame boundary when preemption is built in).
`timescale 1ns/1ps
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV = 2_700_000,
  parameter int N_REQ    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] pat,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               led_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [7:0]       frame;
  logic [2:0]       step;
  logic [2:0]       step_nxt;
  logic             tick;
  logic             clr;
  logic             frame_end;
  logic             owner_req;

  logic             any_req;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [2:0]       win_pat;
  logic [7:0]       win_frame;

  // Prescaler is held cleared in IDLE so the grant edge starts step 0 at cnt=0
  assign clr = (state == ST_IDLE);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign step_nxt  = step + 3'd1;
  assign frame_end = tick && (step == LAST_STEP);
  assign owner_req = req[owner];
  assign win_frame = pat_frame(win_pat);

  // Fixed-priority arbiter: scan from the top so the lowest set index wins
  always_comb begin
    any_req    = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_pat    = PAT_OFF;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req       = 1'b1;
        win_idx       = IDX_W'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_pat       = pat[3*i +: 3];
      end
    end
  end

`ifdef LED_PREEMPT_EN
  logic preempt;

  // Any pending request below the owner's index outranks it
  assign preempt = any_req && (win_idx < owner);
`endif

  // Sequencer FSM with registered gnt/busy/led_out and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= '0;
      frame   <= '0;
      step    <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      led_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gnt     <= '0;
          busy    <= 1'b0;
          led_out <= 1'b0;
          step    <= '0;
          if (any_req) begin
            state   <= ST_RUN;
            owner   <= win_idx;
            frame   <= win_frame;
            gnt     <= win_onehot;
            busy    <= 1'b1;
            led_out <= win_frame[0];
          end
        end

        ST_RUN: begin
          if (!owner_req) begin
            // Release: gnt drops now; a tick on the same edge still applies
            gnt <= '0;
            if (frame_end) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              led_out <= 1'b0;
              step    <= '0;
            end else begin
              state <= ST_DRAIN;
              if (tick) begin
                step    <= step_nxt;
                led_out <= frame[step_nxt];
              end
            end
          end
`ifdef LED_PREEMPT_EN
          else if (frame_end && preempt) begin
            // Hand over at the frame boundary with no IDLE gap
            owner   <= win_idx;
            frame   <= win_frame;
            gnt     <= win_onehot;
            step    <= '0;
            led_out <= win_frame[0];
          end
`endif
          else if (tick) begin
            step    <= step_nxt;
            led_out <= frame[step_nxt];
          end
        end

        ST_DRAIN: begin
          gnt <= '0;
          if (frame_end) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            led_out <= 1'b0;
            step    <= '0;
          end else if (tick) begin
            step    <= step_nxt;
            led_out <= frame[step_nxt];
          end
        end

        default: begin
          state   <= ST_IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          led_out <= 1'b0;
          step    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with TICK_DIV=4, N_REQ=4 (one frame = 32
// cycles). Expected {gnt, busy, led_out} per cycle is queued from a
// timing model of the sequencer and compared 1 time unit after each edge.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int N_REQ     = 4;
  localparam int FRAME_LEN = 8 * TICK_DIV;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] pat;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               led_out;

  // Expected {gnt[3:0], busy, led_out}
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;
  int n_checks;
  int n_fail;

  // Bench-side copy of the pattern table (bit 0 shown first)
  localparam logic [7:0] F_OFF    = 8'b0000_0000;
  localparam logic [7:0] F_ON     = 8'b1111_1111;
  localparam logic [7:0] F_SLOW   = 8'b0000_1111;
  localparam logic [7:0] F_FAST   = 8'b0101_0101;
  localparam logic [7:0] F_HEART  = 8'b0000_0101;
  localparam logic [7:0] F_DOUBLE = 8'b0000_0011;
  localparam logic [7:0] F_TRIPLE = 8'b0111_0111;

  led_pattern_ctrl #(
    .TICK_DIV (TICK_DIV),
    .N_REQ    (N_REQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pat     (pat),
    .gnt     (gnt),
    .busy    (busy),
    .led_out (led_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Queue n idle cycles
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(6'b0);
  endtask

  // Queue one ownership session: granted at entry 0, owner release sampled
  // at edge rel (relative to the grant), frame finished before IDLE.
  task automatic push_grant(input logic [3:0] g, input logic [7:0] f, input int rel);
    int last;
    last = ((rel + FRAME_LEN - 1) / FRAME_LEN) * FRAME_LEN;
    for (int c = 0; c < last; c++) begin
      exp_q.push_back({(c < rel) ? g : 4'b0000, 1'b1, f[(c / TICK_DIV) % 8]});
    end
  endtask

  // Queue n cycles of an owner that has not released, starting at step 0
  task automatic push_run(input logic [3:0] g, input logic [7:0] f, input int n);
    for (int c = 0; c < n; c++) begin
      exp_q.push_back({g, 1'b1, f[(c / TICK_DIV) % 8]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    pat = {3'd1, 3'd1, 3'd1, 3'd2};
    push_idle(3);
    push_grant(4'b0001, F_SLOW, 1);
    push_idle(2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({gnt, busy, led_out} !== exp_v) begin
        n_fail++;
        $display("FAIL reset c=%0d got gnt=%b busy=%b led=%b expected gnt=%b busy=%b led=%b",
                 c, gnt, busy, led_out, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if (c == 2) rst = 1'b0;
      if (c == 3) req = 4'b0000;
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    pat = {3'($urandom_range(0, 7)), 3'd3, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
    push_grant(4'b0100, F_FAST, 14);
    push_idle(2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({gnt, busy, led_out} !== exp_v) begin
        n_fail++;
        $display("FAIL single c=%0d got gnt=%b busy=%b led=%b expected gnt=%b busy=%b led=%b",
                 c, gnt, busy, led_out, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if (c == 13) req = 4'b0000;
    end
  endtask

  task automatic test_release_tick();
    req = 4'b0010;
    pat = {3'd0, 3'd0, 3'd4, 3'd0};
    push_grant(4'b0010, F_HEART, 16);
    push_idle(1);
    push_grant(4'b1000, F_DOUBLE, 32);
    push_idle(2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({gnt, busy, led_out} !== exp_v) begin
        n_fail++;
        $display("FAIL release_tick c=%0d got gnt=%b busy=%b led=%b expected gnt=%b busy=%b led=%b",
                 c, gnt, busy, led_out, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if (c == 15) req = 4'b0000;
      if (c == 32) begin
        req = 4'b1000;
        pat = {3'd5, 3'd0, 3'd0, 3'd0};
      end
      if (c == 64) req = 4'b0000;
    end
  endtask

  task automatic test_simultaneous();
    req = 4'b1010;
    pat = {3'd1, 3'd0, 3'd6, 3'd0};
    push_grant(4'b0010, F_TRIPLE, 40);
    push_idle(1);
    push_grant(4'b0010, F_OFF, 3);
    push_idle(1);
    push_grant(4'b1000, F_ON, 5);
    push_idle(1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({gnt, busy, led_out} !== exp_v) begin
        n_fail++;
        $display("FAIL simultaneous c=%0d got gnt=%b busy=%b led=%b expected gnt=%b busy=%b led=%b",
                 c, gnt, busy, led_out, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if (c == 5)   pat[5:3] = 3'd0;
      if (c == 39)  req[1] = 1'b0;
      if (c == 45)  req[1] = 1'b1;
      if (c == 67)  req[1] = 1'b0;
      if (c == 102) req[3] = 1'b0;
    end
  endtask

  task automatic test_preempt();
    req = 4'b1000;
    pat = {3'd1, 3'd0, 3'd0, 3'd0};
`ifdef LED_PREEMPT_EN
    push_run(4'b1000, F_ON, FRAME_LEN);
    push_grant(4'b0001, F_OFF, 2);
    push_idle(2);
`else
    push_grant(4'b1000, F_ON, 40);
    push_idle(1);
    push_grant(4'b0001, F_OFF, 2);
    push_idle(1);
`endif
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({gnt, busy, led_out} !== exp_v) begin
        n_fail++;
        $display("FAIL preempt c=%0d got gnt=%b busy=%b led=%b expected gnt=%b busy=%b led=%b",
                 c, gnt, busy, led_out, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if (c == 9) req[0] = 1'b1;
`ifdef LED_PREEMPT_EN
      if (c == 33) req[0] = 1'b0;
      if (c == 35) req[3] = 1'b0;
`else
      if (c == 39) req[3] = 1'b0;
      if (c == 66) req[0] = 1'b0;
`endif
    end
  endtask

  task automatic test_reset_midframe();
    req = 4'b0100;
    pat = {3'd0, 3'd1, 3'd0, 3'd0};
    push_run(4'b0100, F_ON, 10);
    push_idle(1);
    push_grant(4'b0100, F_ON, 1);
    push_idle(1);
    for (int c = 0; exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({gnt, busy, led_out} !== exp_v) begin
        n_fail++;
        $display("FAIL reset_midframe c=%0d got gnt=%b busy=%b led=%b expected gnt=%b busy=%b led=%b",
                 c, gnt, busy, led_out, exp_v[5:2], exp_v[1], exp_v[0]);
      end
      if (c == 9)  rst = 1'b1;
      if (c == 10) rst = 1'b0;
      if (c == 11) req = 4'b0000;
    end
  endtask

  // Sequence of scenarios and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    pat      = '0;
    test_reset();
    test_single();
    test_release_tick();
    test_simultaneous();
    test_preempt();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
